// File: rtl/alu_8bit_if.sv
// alu_8bit_if: operand/opcode bus into the ALU and registered results back out.
interface alu_8bit_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic [7:0] x;
  logic [7:0] y;
  modport master (output a, b, opcode, input x, y);
  modport slave (input a, b, opcode, output x, y);
endinterface

// File: rtl/alu_8bit.sv
// alu_8bit: 16-function unsigned 8-bit ALU with registered primary (x) and secondary (y) results.
module alu_8bit (
  input logic       clk,
  input logic       rst,
  alu_8bit_if.slave bus
);
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [8:0] sum, dif, inc;
  logic [15:0] prod;
  logic [7:0] a, b;
  assign a = bus.a;
  assign b = bus.b;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign inc = {1'b0, a} + 9'd1;
  assign prod = a * b;
  always_comb begin
    x_d = '0;
    y_d = '0;
    case (bus.opcode)
      4'd0:  {y_d[0], x_d} = sum;
      4'd1:  {y_d[0], x_d} = dif;
      4'd2:  {y_d, x_d} = prod;
      // A zero divisor yields all-ones quotient and passes a through as remainder.
      4'd3:  begin
        x_d = (b == 8'd0) ? 8'hFF : a / b;
        y_d = (b == 8'd0) ? a : a % b;
      end
      4'd4:  x_d = a & b;
      4'd5:  x_d = a | b;
      4'd6:  x_d = a ^ b;
      4'd7:  begin
        x_d = ~a;
        y_d = ~b;
      end
      4'd8:  x_d = ~(a | b);
      4'd9:  x_d = ~(a ^ b);
      4'd10: {y_d[0], x_d} = {a, 1'b0};
      4'd11: {x_d, y_d[0]} = {1'b0, a};
      4'd12: x_d = {a[6:0], a[7]};
      4'd13: x_d = {a[0], a[7:1]};
      4'd14: x_d = {5'b0, a > b, a == b, a < b};
      default: {y_d[0], x_d} = inc;
    endcase
  end
  always_ff @(posedge clk) begin
    x_q <= rst ? 8'h00 : x_d;
    y_q <= rst ? 8'h00 : y_d;
  end
  assign bus.x = x_q;
  assign bus.y = y_q;
endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed and randomized checks of alu_8bit against an arithmetic reference model.
module tb_alu_8bit;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  alu_8bit_if bus ();
  alu_8bit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] op);
    int ai, bi, xr, yr;
    ai = int'(av);
    bi = int'(bv);
    xr = 0;
    yr = 0;
    case (op)
      0: begin xr = (ai + bi) % 256; yr = (ai + bi) / 256; end
      1: begin xr = (ai - bi + 256) % 256; yr = (ai < bi) ? 1 : 0; end
      2: begin xr = (ai * bi) % 256; yr = (ai * bi) / 256; end
      3: begin xr = (bi == 0) ? 255 : ai / bi; yr = (bi == 0) ? ai : ai % bi; end
      4: xr = int'(av & bv);
      5: xr = int'(av | bv);
      6: xr = int'(av ^ bv);
      7: begin xr = 255 - ai; yr = 255 - bi; end
      8: xr = 255 - int'(av | bv);
      9: xr = 255 - int'(av ^ bv);
      10: begin xr = (ai * 2) % 256; yr = ai / 128; end
      11: begin xr = ai / 2; yr = ai % 2; end
      12: xr = (ai * 2) % 256 + ai / 128;
      13: xr = ai / 2 + (ai % 2) * 128;
      14: xr = (ai > bi) ? 4 : (ai == bi) ? 2 : 1;
      default: begin xr = (ai + 1) % 256; yr = (ai + 1) / 256; end
    endcase
    return 16'(yr * 256 + xr);
  endfunction

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] op);
    bus.a = av;
    bus.b = bv;
    bus.opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      drive(8'h55, 8'hC3, 4'd0);
      checks++;
      if ({bus.y, bus.x} !== 16'h0000) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got y=%h x=%h want y=00 x=00", i, bus.y, bus.x);
      end
    end
    rst = 0;
    drive(8'h55, 8'hC3, 4'd0);
    checks++;
    if ({bus.y, bus.x} !== 16'h0118) begin
      failures++;
      $display("FAIL reset_release: got y=%h x=%h want y=01 x=18", bus.y, bus.x);
    end
  endtask

  task automatic test_sweep;
    logic [15:0] exp_tab [16] = '{16'h0118, 16'h0192, 16'h40BF, 16'h5500,
                                  16'h0041, 16'h00D7, 16'h0096, 16'h3CAA,
                                  16'h0028, 16'h0069, 16'h00AA, 16'h012A,
                                  16'h00AA, 16'h00AA, 16'h0001, 16'h0056};
    for (int op = 0; op < 16; op++) begin
      drive(8'h55, 8'hC3, 4'(op));
      checks++;
      if ({bus.y, bus.x} !== exp_tab[op]) begin
        failures++;
        $display("FAIL sweep op=%0d: got y=%h x=%h want y=%h x=%h", op, bus.y, bus.x, exp_tab[op][15:8], exp_tab[op][7:0]);
      end
    end
  endtask

  task automatic test_div_zero;
    drive(8'h37, 8'h00, 4'd3);
    checks++;
    if ({bus.y, bus.x} !== 16'h37FF) begin
      failures++;
      $display("FAIL div_zero: got y=%h x=%h want y=37 x=FF", bus.y, bus.x);
    end
  endtask

  task automatic test_wrap;
    drive(8'hFF, 8'h01, 4'd0);
    checks++;
    if ({bus.y, bus.x} !== 16'h0100) begin
      failures++;
      $display("FAIL add_wrap: got y=%h x=%h want y=01 x=00", bus.y, bus.x);
    end
    drive(8'hFF, 8'hA5, 4'd15);
    checks++;
    if ({bus.y, bus.x} !== 16'h0100) begin
      failures++;
      $display("FAIL inc_wrap: got y=%h x=%h want y=01 x=00", bus.y, bus.x);
    end
    drive(8'hFF, 8'hFF, 4'd2);
    checks++;
    if ({bus.y, bus.x} !== 16'hFE01) begin
      failures++;
      $display("FAIL mul_max: got y=%h x=%h want y=FE x=01", bus.y, bus.x);
    end
    drive(8'h7C, 8'h7C, 4'd1);
    checks++;
    if ({bus.y, bus.x} !== 16'h0000) begin
      failures++;
      $display("FAIL sub_equal: got y=%h x=%h want y=00 x=00", bus.y, bus.x);
    end
  endtask

  task automatic test_compare;
    drive(8'h80, 8'h80, 4'd14);
    checks++;
    if ({bus.y, bus.x} !== 16'h0002) begin
      failures++;
      $display("FAIL cmp_equal: got y=%h x=%h want y=00 x=02", bus.y, bus.x);
    end
    drive(8'hC3, 8'h55, 4'd14);
    checks++;
    if ({bus.y, bus.x} !== 16'h0004) begin
      failures++;
      $display("FAIL cmp_greater: got y=%h x=%h want y=00 x=04", bus.y, bus.x);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] av, bv;
    logic [3:0] op;
    logic [15:0] e;
    for (int i = 0; i < 400; i++) begin
      av = 8'($urandom);
      bv = (i % 10 == 0) ? 8'h00 : 8'($urandom);
      op = 4'($urandom_range(0, 15));
      e = model(av, bv, op);
      drive(av, bv, op);
      checks++;
      if ({bus.y, bus.x} !== e) begin
        failures++;
        $display("FAIL random op=%0d a=%h b=%h: got y=%h x=%h want y=%h x=%h", op, av, bv, bus.y, bus.x, e[15:8], e[7:0]);
      end
      bus.a = ~av;
      bus.b = ~bv;
      bus.opcode = ~op;
      @(negedge clk);
      checks++;
      if ({bus.y, bus.x} !== e) begin
        failures++;
        $display("FAIL hold_between_edges op=%0d: got y=%h x=%h want y=%h x=%h", op, bus.y, bus.x, e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive(8'h12, 8'h34, 4'd4);
    checks++;
    if ({bus.y, bus.x} !== 16'h0010) begin
      failures++;
      $display("FAIL pre_mul_and: got y=%h x=%h want y=00 x=10", bus.y, bus.x);
    end
    rst = 1;
    drive(8'hFF, 8'hFF, 4'd2);
    checks++;
    if ({bus.y, bus.x} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_midstream: got y=%h x=%h want y=00 x=00", bus.y, bus.x);
    end
    rst = 0;
    drive(8'h03, 8'h05, 4'd0);
    checks++;
    if ({bus.y, bus.x} !== 16'h0008) begin
      failures++;
      $display("FAIL after_midstream_reset: got y=%h x=%h want y=00 x=08", bus.y, bus.x);
    end
  endtask

  initial begin
    bus.a = 0;
    bus.b = 0;
    bus.opcode = 0;
    test_reset;
    test_sweep;
    test_div_zero;
    test_wrap;
    test_compare;
    test_back_to_back;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit, 16-function registered ALU for the datapath.
- Each cycle it samples operands a, b and a 4-bit opcode, then registers a primary result x and a secondary/extension result y.
- Covers arithmetic (add, sub, mul, div, inc), bitwise logic, shift/rotate and compare.
- No handshake; a new operation may be issued every cycle.

Parameters:
- None. Data width is fixed at 8 and opcode width at 4.

Ports:
- clk     input   1  system clock; all state updates on its rising edge.
- rst     input   1  synchronous, active-high reset.
- a       input   8  operand A, unsigned.
- b       input   8  operand B, unsigned.
- opcode  input   4  operation select.
- x       output  8  primary result, registered.
- y       output  8  secondary result (carry, borrow, high product, remainder, shifted-out bit), registered.

Behaviour:
- Reset:
  - On a rising clk edge with rst=1, x=8'h00 and y=8'h00.
  - rst has priority over any operation, including when asserted mid-stream.
  - Outputs stay 0 while rst is held.
- Latency:
  - a, b and opcode are sampled at rising edge N.
  - x and y reflect that operation after edge N and hold until edge N+1.
  - Fully pipelined, one result per cycle, no stalls.
  - Combinational result logic feeds the x/y flops only.
  - x and y must not change between clock edges.
- All arithmetic is unsigned. Any y bits not listed below are 0.
- Opcode map:
  - 0 ADD: {y[0],x} = a+b (9-bit sum). y[0] = carry out.
  - 1 SUB: x = a-b mod 256. y[0] = borrow (1 when a<b).
  - 2 MUL: {y,x} = a*b (16-bit product). y = high byte.
  - 3 DIV: x = a/b, y = a%b.
    - Divide by zero (b=0): x=8'hFF, y=a. No trap, no X propagation.
  - 4 AND: x = a&b, y=0.
  - 5 OR: x = a|b, y=0.
  - 6 XOR: x = a^b, y=0.
  - 7 NOT: x = ~a, y = ~b.
  - 8 NOR: x = ~(a|b), y=0.
  - 9 XNOR: x = ~(a^b), y=0.
  - 10 SHL: x = a<<1 with zero fill. y[0] = a[7].
  - 11 SHR: x = a>>1 (logical). y[0] = a[0].
  - 12 ROL: x = {a[6:0],a[7]}, y=0.
  - 13 ROR: x = {a[0],a[7:1]}, y=0.
  - 14 CMP: x = {5'b0, a>b, a==b, a<b}. Exactly one bit set. y=0.
  - 15 INC: {y[0],x} = a+1. b is ignored.
    - Wrap-around: a=8'hFF gives x=0, y=1.
- Operand b is ignored by opcodes 10–13 and 15.
- Boundary conditions:
  - ADD 8'hFF+8'h01: x=0, y=1.
  - SUB with a==b: x=0, y=0.
  - MUL 8'hFF*8'hFF: y=8'hFE, x=8'h01.
- Every opcode value is defined; there is no illegal-opcode state.

Test Plan:
- Reset:
  - Hold rst=1 for 2 cycles with a=8'h55, b=8'hC3, opcode=0 → x=0, y=0.
  - Release rst → next edge gives x=8'h18, y=8'h01.
- Opcode sweep: a=8'h55, b=8'hC3, opcode 0..15, one per cycle (x/y one cycle later):
  - ADD 18/01, SUB 92/01, MUL BF/40, DIV 00/55
  - AND 41/00, OR D7/00, XOR 96/00, NOT AA/3C
  - NOR 28/00, XNOR 69/00, SHL AA/00, SHR 2A/01
  - ROL AA/00, ROR AA/00, CMP 01/00, INC 56/00
- Divide by zero: a=8'h37, b=0, opcode=3 → x=8'hFF, y=8'h37.
- Wrap/carry:
  - ADD FF+01 → x=00, y=01.
  - INC a=FF → x=00, y=01.
  - MUL FF*FF → x=01, y=FE.
- Compare:
  - a=b=8'h80, opcode=14 → x=8'h02.
  - a=8'hC3, b=8'h55, opcode=14 → x=8'h04.
- Reset mid-stream: issue MUL, assert rst on the next edge → x=0, y=0 on that edge; the MUL result never appears.
